// File: rtl/dspl_pkg.sv
// Shared display definitions: active-low segment table, digit field layout and anode selects.
// Used by both the display monitor and the display driver.
package dspl_pkg;

   localparam int unsigned EN_BIT  = 5;
   localparam int unsigned HEX_MSB = 4;
   localparam int unsigned HEX_LSB = 1;
   localparam int unsigned DP_BIT  = 0;

   typedef logic [5:0] digit_t;

   // Active-low gfedcba patterns for hex digits 0..F
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   // Active-low anode selects; entry 0 drives d1 (an[7]), entry 7 drives d8 (an[0])
   localparam logic [7:0] AN_SEL [8] = '{
      8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE
   };

   localparam logic [7:0] AN_NONE = 8'hFF;

   function automatic digit_t make_digit(input logic [3:0] hex, input logic dp_lit);
      return {1'b1, hex, dp_lit};
   endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational 7-segment decoder: active-low gfedcba pattern to {match, hex}.
module seg_decode
   import dspl_pkg::*;
(
   input  logic [6:0] seg,
   output logic       match,
   output logic [3:0] hex
);

   always_comb begin
      match = 1'b0;
      hex   = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (seg == SEG_TABLE[i]) begin
            match = 1'b1;
            hex   = 4'(i);
         end
      end
   end

endmodule

// File: rtl/dspl_mon_nexysa7.sv
// Snoops the Nexys A7 7-segment anode/cathode lines and reconstructs the eight displayed digits,
// marking a digit disabled once it has not been refreshed for TIMEOUT_MS.
module dspl_mon_nexysa7
   import dspl_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 16,
   parameter int unsigned TICK_CYCLES   = 100_000,
   parameter int unsigned TIMEOUT_MS    = 12
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] an,
   input  logic [7:0] dec_cat,
   output logic [5:0] d1,
   output logic [5:0] d2,
   output logic [5:0] d3,
   output logic [5:0] d4,
   output logic [5:0] d5,
   output logic [5:0] d6,
   output logic [5:0] d7,
   output logic [5:0] d8,
   output logic       upd,
   output logic       err
);

   localparam int unsigned CW = $clog2(STABLE_CYCLES + 2);
   localparam int unsigned PW = $clog2(TICK_CYCLES + 1);
   localparam int unsigned AW = $clog2(TIMEOUT_MS + 1);

   logic [15:0]   sync1_q, sync2_q, prev_q;
   logic [1:0]    vld_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] pre_q;
   logic [AW-1:0] age_q [8];
   digit_t        dig_q [8];
   logic          upd_q, err_q;

   logic [7:0] an_s, cat_s;
   logic       accept, tick, one_low, match, wr, bad;
   logic [3:0] hex;
   logic [2:0] wr_idx;

   assign {an_s, cat_s} = sync2_q;

   // vld_q keeps reset-cleared synchronizer contents out of the stability count
   always_comb begin
      if (!vld_q[1]) begin
         cnt_d = '0;
      end else if (sync2_q != prev_q) begin
         cnt_d = CW'(1);
      end else if (cnt_q == CW'(STABLE_CYCLES + 1)) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   assign accept = (cnt_d == CW'(STABLE_CYCLES));
   assign tick   = (pre_q == PW'(TICK_CYCLES - 1));

   seg_decode u_seg_decode (
      .seg   (cat_s[7:1]),
      .match (match),
      .hex   (hex)
   );

   always_comb begin
      one_low = 1'b0;
      wr_idx  = '0;
      for (int i = 0; i < 8; i++) begin
         if (an_s == AN_SEL[i]) begin
            one_low = 1'b1;
            wr_idx  = 3'(i);
         end
      end
   end

   assign wr  = accept && one_low && match;
   assign bad = accept && (an_s != AN_NONE) && !(one_low && match);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         vld_q   <= '0;
         cnt_q   <= '0;
         pre_q   <= '0;
         upd_q   <= 1'b0;
         err_q   <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            age_q[i] <= '0;
            dig_q[i] <= '0;
         end
      end else begin
         sync1_q <= {an, dec_cat};
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         vld_q   <= {vld_q[0], 1'b1};
         cnt_q   <= cnt_d;
         pre_q   <= tick ? '0 : pre_q + PW'(1);
         upd_q   <= wr;
         err_q   <= bad;
         for (int i = 0; i < 8; i++) begin
            if (wr && (wr_idx == 3'(i))) begin
               dig_q[i] <= make_digit(hex, ~cat_s[0]);
               age_q[i] <= '0;
            end else begin
               if (tick && (age_q[i] != AW'(TIMEOUT_MS))) begin
                  age_q[i] <= age_q[i] + AW'(1);
               end
               if (age_q[i] == AW'(TIMEOUT_MS)) begin
                  dig_q[i][EN_BIT] <= 1'b0;
               end
            end
         end
      end
   end

   assign d1  = dig_q[0];
   assign d2  = dig_q[1];
   assign d3  = dig_q[2];
   assign d4  = dig_q[3];
   assign d5  = dig_q[4];
   assign d6  = dig_q[5];
   assign d7  = dig_q[6];
   assign d8  = dig_q[7];
   assign upd = upd_q;
   assign err = err_q;

endmodule

// File: tb/tb_dspl_mon_nexysa7.sv
// Self-checking bench for dspl_mon_nexysa7: vector table plus scoreboard of expected upd/err events.
module tb_dspl_mon_nexysa7;

   localparam int unsigned STABLE  = 16;
   localparam int unsigned TICK    = 100;
   localparam int unsigned TIMEOUT = 12;
   localparam int unsigned LAT     = STABLE + 2;

   typedef struct {
      logic [7:0] an;
      logic [7:0] cat;
      logic [1:0] kind;   // {upd, err} expected
      int         idx;
      logic [5:0] dval;
   } vec_t;

   typedef struct {
      logic [1:0] kind;
      int         idx;
      logic [5:0] dval;
      int         cyc;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] an = 8'hFF;
   logic [7:0] dec_cat = 8'hFF;
   logic [5:0] dq [8];
   logic       upd, err;

   int         cyc = 0;
   int         n_chk = 0;
   int         n_pass = 0;
   exp_t       sb [$];
   logic [5:0] exp_d [8];
   vec_t       tbl [10];
   int         rel;

   dspl_mon_nexysa7 #(
      .STABLE_CYCLES (STABLE),
      .TICK_CYCLES   (TICK),
      .TIMEOUT_MS    (TIMEOUT)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .an      (an),
      .dec_cat (dec_cat),
      .d1      (dq[0]),
      .d2      (dq[1]),
      .d3      (dq[2]),
      .d4      (dq[3]),
      .d5      (dq[4]),
      .d6      (dq[5]),
      .d7      (dq[6]),
      .d8      (dq[7]),
      .upd     (upd),
      .err     (err)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
   endtask

   // Every upd/err pulse must match the oldest outstanding expectation
   always @(negedge clock) begin
      exp_t e;
      if (!reset && (upd || err)) begin
         if (sb.size() == 0) begin
            check("unexpected_event", {30'b0, upd, err}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("event_kind", {30'b0, upd, err}, {30'b0, e.kind});
            check("event_cycle", cyc, e.cyc);
            if (e.kind == 2'b10) check("written_digit", {26'b0, dq[e.idx]}, {26'b0, e.dval});
         end
      end
   end

   task automatic drive(input logic [7:0] a, input logic [7:0] c, input logic [1:0] kind,
                        input int idx, input logic [5:0] dv, input int hold);
      exp_t e;
      @(posedge clock);
      #1;
      an      = a;
      dec_cat = c;
      if (kind != 2'b00) begin
         e.kind = kind;
         e.idx  = idx;
         e.dval = dv;
         e.cyc  = cyc + LAT;
         sb.push_back(e);
         if (kind == 2'b10) exp_d[idx] = dv;
      end
      repeat (hold - 1) @(posedge clock);
   endtask

   task automatic check_digits(input string name);
      @(negedge clock);
      for (int i = 0; i < 8; i++) check(name, {26'b0, dq[i]}, {26'b0, exp_d[i]});
   endtask

   initial begin
      tbl[0] = '{8'h7F, {7'b0100100, 1'b0}, 2'b10, 0, 6'b1_0010_1};
      tbl[1] = '{8'hFE, {7'b0001110, 1'b1}, 2'b10, 7, 6'b1_1111_0};
      tbl[2] = '{8'hFF, 8'h00,              2'b00, 0, 6'b0};
      tbl[3] = '{8'h3F, {7'b0100100, 1'b0}, 2'b01, 0, 6'b0};
      tbl[4] = '{8'hDF, {7'b1111111, 1'b1}, 2'b01, 0, 6'b0};
      tbl[5] = '{8'hDF, {7'b1000000, 1'b1}, 2'b10, 2, 6'b1_0000_0};
      tbl[6] = '{8'hEF, {7'b0000011, 1'b0}, 2'b10, 3, 6'b1_1011_1};
      tbl[7] = '{8'hF7, {7'b1111001, 1'b1}, 2'b10, 4, 6'b1_0001_0};
      tbl[8] = '{8'hFB, {7'b0101010, 1'b0}, 2'b01, 0, 6'b0};
      tbl[9] = '{8'h00, {7'b0100100, 1'b0}, 2'b01, 0, 6'b0};
      for (int i = 0; i < 8; i++) exp_d[i] = '0;

      // Reset state
      #12;
      for (int i = 0; i < 8; i++) check("reset_digit", {26'b0, dq[i]}, 32'd0);
      check("reset_upd", {31'b0, upd}, 32'd0);
      check("reset_err", {31'b0, err}, 32'd0);
      @(posedge clock);
      #3;
      reset = 1'b0;

      for (int v = 0; v < 10; v++) begin
         drive(tbl[v].an, tbl[v].cat, tbl[v].kind, tbl[v].idx, tbl[v].dval, 20);
         check_digits("vector_digits");
      end

      // Short glitch between two stable patterns must not be accepted
      drive(8'h7F, {7'b0001000, 1'b1}, 2'b10, 0, 6'b1_1010_0, 20);
      drive(8'hBF, {7'b0010010, 1'b0}, 2'b00, 0, 6'b0, 10);
      drive(8'h7F, {7'b1111000, 1'b0}, 2'b10, 0, 6'b1_0111_1, 20);
      check_digits("glitch_digits");

      // Asynchronous reset mid-stream
      drive(8'hDF, {7'b0000110, 1'b0}, 2'b00, 0, 6'b0, 10);
      #3;
      reset = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) check("midreset_digit", {26'b0, dq[i]}, 32'd0);
      check("midreset_upd", {31'b0, upd}, 32'd0);
      check("midreset_err", {31'b0, err}, 32'd0);
      for (int i = 0; i < 8; i++) exp_d[i] = '0;
      repeat (2) @(posedge clock);
      #3;
      reset = 1'b0;
      rel = cyc;
      sb.push_back('{2'b10, 2, 6'b1_1110_1, rel + LAT});
      exp_d[2] = 6'b1_1110_1;
      repeat (LAT + 2) @(posedge clock);
      check_digits("post_reset_digits");

      // Aging: prescaler restarted at release, so the 12th tick lands on edge rel+1200
      drive(8'hFF, 8'h00, 2'b00, 0, 6'b0, 20);
      while (cyc < rel + int'(TIMEOUT * TICK)) @(negedge clock);
      check("age_before_timeout", {26'b0, dq[2]}, {26'b0, 6'b1_1110_1});
      @(negedge clock);
      check("age_after_timeout", {26'b0, dq[2]}, {26'b0, 6'b0_1110_1});
      exp_d[2] = 6'b0_1110_1;
      check_digits("timeout_digits");

      // Refresh every 8 ms keeps the digit enabled
      for (int k = 0; k < 3; k++) begin
         drive(8'hDF, {7'b0000110, 1'b0}, 2'b10, 2, 6'b1_1110_1, 20);
         drive(8'hFF, 8'h00, 2'b00, 0, 6'b0, 780);
         @(negedge clock);
         check("refresh_enable", {31'b0, dq[2][5]}, 32'd1);
      end
      check_digits("final_digits");

      repeat (4) @(posedge clock);
      check("scoreboard_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
